// File: rtl/tx_arb_pkg.sv
// rtl/tx_arb_pkg.sv - shared constants and helpers for the transmit arbiter
package tx_arb_pkg;

   // FSM state encoding
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] LAUNCH = 2'd1;
   localparam logic [1:0] HOLD   = 2'd2;

   // Frame window matching the 10-bit serial frame plus edge detect
   localparam int FRAME_CYCLES_DEF = 12;

   // Ceiling log2, never less than 1 so single-bit fields stay legal
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - requester search; TX_ARB_FIXED_PRIO_EN selects lowest-index priority
module rr_picker
   import tx_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int GW = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GW-1:0]      ptr,
   output logic [GW-1:0]      winner,
   output logic               found
);

`ifdef TX_ARB_FIXED_PRIO_EN
   // Lowest set bit wins; scanning downward lets the lowest index overwrite last
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            winner = GW'(i);
            found  = 1'b1;
         end
      end
   end

   logic unused_ptr;
   assign unused_ptr = ^ptr;
`else
   // First set bit at or above the pointer with wrap; smallest offset written last
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(ptr) + k) % NUM_REQ;
         if (req[idx]) begin
            winner = GW'(idx);
            found  = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin byte scheduler for one serial transmitter; option TX_ARB_FIXED_PRIO_EN
module tx_arbiter
   import tx_arb_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
   localparam int GW = clog2(NUM_REQ),
   localparam int CW = clog2(FRAME_CYCLES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]     ack,
   output logic                   tx_send,
   output logic [7:0]             tx_data,
   output logic                   busy,
   output logic [GW-1:0]          grant_id
);

   logic [1:0]    state;
   logic [GW-1:0] ptr;
   logic [CW-1:0] cnt;
   logic [GW-1:0] win;
   logic          found;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req    (req),
      .ptr    (ptr),
      .winner (win),
      .found  (found)
   );

   // Grant FSM: the counter starts at the launch edge so the whole window,
   // LAUNCH included, lasts FRAME_CYCLES and grants are FRAME_CYCLES+1 apart
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ptr      <= '0;
         cnt      <= '0;
         ack      <= '0;
         tx_send  <= 1'b0;
         tx_data  <= 8'h00;
         busy     <= 1'b0;
         grant_id <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  tx_data  <= req_data[8*int'(win) +: 8];
                  grant_id <= win;
`ifndef TX_ARB_FIXED_PRIO_EN
                  ptr      <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
`endif
                  ack      <= NUM_REQ'(1) << win;
                  tx_send  <= 1'b1;
                  busy     <= 1'b1;
                  cnt      <= CW'(FRAME_CYCLES - 1);
                  state    <= LAUNCH;
               end
            end
            LAUNCH: begin
               ack     <= '0;
               tx_send <= 1'b0;
               cnt     <= cnt - 1'b1;
               state   <= HOLD;
            end
            HOLD: begin
               if (cnt == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               ack     <= '0;
               tx_send <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - self-checking bench for tx_arbiter with a timestamp model
module tb_tx_arbiter;

   localparam int N  = 4;
   localparam int FC = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]  ack;
   logic          tx_send;
   logic [7:0]    tx_data;
   logic          busy;
   logic [1:0]    grant_id;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   tx_arbiter #(.NUM_REQ(N), .FRAME_CYCLES(FC)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .tx_send  (tx_send),
      .tx_data  (tx_data),
      .busy     (busy),
      .grant_id (grant_id)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: a grant is possible once FC cycles have elapsed since the last
   // launch; the winner comes from a rotating (or lowest-index) search.
   int         m_ptr = 0;
   int         m_last = -1000;
   int         m_cyc = 0;
   logic       e_send = 0;
   logic [N-1:0] e_ack = 0;
   logic [7:0] e_data = 0;
   logic [1:0] e_gid = 0;
   logic       e_busy = 0;

   function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef TX_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (r[i]) return i;
`else
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
      return -1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_ptr = 0; m_last = -1000; m_cyc = 0;
         e_send = 0; e_ack = 0; e_data = 0; e_gid = 0; e_busy = 0;
      end else begin
         int w;
         m_cyc = m_cyc + 1;
         e_send = 0;
         e_ack = 0;
         w = pick(req, m_ptr);
         if ((m_cyc - 1) >= (m_last + FC) && w >= 0) begin
            e_data = req_data[8*w +: 8];
            e_gid  = 2'(w);
            m_ptr  = (w + 1) % N;
            m_last = m_cyc;
            e_send = 1;
            e_ack  = N'(1) << w;
         end
         e_busy = (m_cyc - m_last) < FC;
      end
   end

   always @(negedge clk) begin
      chk("cmp_tx_send", 32'(tx_send), 32'(e_send));
      chk("cmp_ack", 32'(ack), 32'(e_ack));
      chk("cmp_tx_data", 32'(tx_data), 32'(e_data));
      chk("cmp_busy", 32'(busy), 32'(e_busy));
      chk("cmp_grant_id", 32'(grant_id), 32'(e_gid));
   end

   int ack3_hits = 0;
   logic watch3 = 0;
   always @(negedge clk) if (watch3 && ack[3]) ack3_hits++;

   task automatic wait_send(input string nm, output int gid, output int at);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tx_send && n < 60);
      if (!tx_send) begin
         checks++;
         errors++;
         $display("FAIL %s: no tx_send within 60 cycles, got 0 expected 1", nm);
      end
      gid = int'(grant_id);
      at  = cyc;
   endtask

   task automatic drive(input logic [N-1:0] r);
      @(posedge clk);
      #1;
      req = r;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      req = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      int g, t, t0, c;
      int gids[5];
      int ts[5];
      logic [N-1:0] ackmem;

      // reset with all requesters asserted
      rst = 1'b0;
      req = 4'b1111;
      req_data = 32'h13121110;
      repeat (3) begin
         @(negedge clk);
         chk("rst_ack", 32'(ack), 0);
         chk("rst_tx_send", 32'(tx_send), 0);
         chk("rst_tx_data", 32'(tx_data), 0);
         chk("rst_busy", 32'(busy), 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      wait_send("first_grant", g, t);
      chk("first_grant_id", 32'(g), 0);
      chk("first_ack", 32'(ack), 32'h1);
      drive('0);
      repeat (14) @(posedge clk);

      // single request, byte held for the whole frame
      #1;
      req_data[23:16] = 8'hA5;
      req = 4'b0100;
      c = cyc;
      wait_send("single", g, t);
      chk("single_latency", 32'(t - c), 1);
      chk("single_gid", 32'(g), 2);
      chk("single_ack", 32'(ack), 32'h4);
      chk("single_data", 32'(tx_data), 32'hA5);
      drive('0);
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         else @(negedge clk);
         chk("single_hold_data", 32'(tx_data), 32'hA5);
         chk("single_send_low", 32'(tx_send), 0);
      end
      repeat (3) @(posedge clk);

      // wrap and skip: pointer sits at 3, requester 3 idle
      #1;
      req_data[15:0] = 16'h2221;
      req = 4'b0011;
      wait_send("wrap0", g, t);
      chk("wrap_first", 32'(g), 0);
      drive(4'b0010);
      wait_send("wrap1", g, t);
      chk("wrap_second", 32'(g), 1);
      chk("wrap_data", 32'(tx_data), 32'h22);
      drive('0);
      repeat (14) @(posedge clk);

      // fairness with everyone requesting continuously
      do_reset();
      req_data = 32'h13121110;
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_send("rotate", gids[i], ts[i]);
         chk("rotate_data", 32'(tx_data), 32'(8'h10 + gids[i]));
      end
      for (int i = 0; i < 5; i++) begin
`ifdef TX_ARB_FIXED_PRIO_EN
         chk("rotate_order", 32'(gids[i]), 0);
`else
         chk("rotate_order", 32'(gids[i]), 32'(i % N));
`endif
         if (i > 0) chk("rotate_spacing", 32'(ts[i] - ts[i-1]), 13);
      end
      drive('0);
      repeat (14) @(posedge clk);

      // arrivals during HOLD
      do_reset();
      #1;
      req_data = 32'h77665555;
      req = 4'b0001;
      watch3 = 1'b1;
      wait_send("mid0", g, t0);
      chk("mid_first", 32'(g), 0);
      drive('0);
      repeat (2) @(posedge clk);
      #1;
      req = 4'b1010;
      repeat (4) @(posedge clk);
      #1;
      req = 4'b0010;
      wait_send("mid1", g, t);
      chk("mid_second", 32'(g), 1);
      chk("mid_spacing", 32'(t - t0), 13);
      drive('0);
      repeat (14) @(posedge clk);
      watch3 = 1'b0;
      chk("mid_no_ack3", 32'(ack3_hits), 0);

      // asynchronous reset in the middle of HOLD
      #1;
      req = 4'b1000;
      wait_send("areset0", g, t);
      chk("areset_first", 32'(g), 3);
      drive('0);
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("areset_busy", 32'(busy), 0);
      chk("areset_send", 32'(tx_send), 0);
      chk("areset_data", 32'(tx_data), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      req_data[15:8] = 8'h99;
      req = 4'b0010;
      wait_send("areset1", g, t);
      chk("areset_after", 32'(g), 1);
      chk("areset_after_data", 32'(tx_data), 32'h99);
      drive('0);
      repeat (14) @(posedge clk);

      // random requesters following the handshake
      ackmem = '0;
      repeat (3000) begin
         @(posedge clk);
         #1;
         if ($urandom_range(0, 599) == 0) begin
            #2;
            rst = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b1;
            ackmem = '0;
         end
         for (int i = 0; i < N; i++) begin
            if (ackmem[i]) begin
               if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
               else req_data[8*i +: 8] = 8'($urandom);
            end else if (!req[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req_data[8*i +: 8] = 8'($urandom);
                  req[i] = 1'b1;
               end
            end else if ($urandom_range(0, 31) == 0) begin
               req[i] = 1'b0;
            end
         end
         ackmem = ack;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
